// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one 4-bit mux rotator between two requesters,
// with a single registered valid/ready result stage.

module rotate_rot4 (
  input  logic [3:0] data,
  input  logic       dir,
  input  logic [1:0] amt,
  output logic [3:0] rot
);
  // Right by k: rot[j] = data[j+k]; left by k: rot[j] = data[j-k]; right 3 == left 1.
  always_comb begin
    rot = data;
    case (amt)
      2'd0: rot = data;
      2'd1: rot = dir ? {data[0], data[3:1]} : {data[2:0], data[3]};
      2'd2: rot = {data[1:0], data[3:2]};
      2'd3: rot = dir ? {data[2:0], data[3]} : {data[0], data[3:1]};
      default: rot = data;
    endcase
  end
endmodule

module rotate_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req0_data,
  input  logic [3:0] req1_data,
  input  logic       req0_dir,
  input  logic       req1_dir,
  input  logic [1:0] req0_amt,
  input  logic [1:0] req1_amt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_id
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic            last_id;
  logic [1:0]      grant;
  logic            can_accept;
  logic            xfer;
  logic            sel;
  logic [1:0][3:0] req_data;
  logic [1:0]      req_dir;
  logic [1:0][1:0] req_amt;
  logic [3:0]      rot;

  assign req_data = {req1_data, req0_data};
  assign req_dir  = {req1_dir, req0_dir};
  assign req_amt  = {req1_amt, req0_amt};

  // On a tie the requester that was not served last wins.
  assign grant[0] = req_valid[0] && (!req_valid[1] || last_id);
  assign grant[1] = req_valid[1] && (!req_valid[0] || !last_id);

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  assign req_ready  = (rst_n && can_accept) ? grant : 2'b00;
  assign xfer       = |(req_valid & req_ready);
  assign sel        = req_ready[1];

  rotate_rot4 u_rot (
    .data (req_data[sel]),
    .dir  (req_dir[sel]),
    .amt  (req_amt[sel]),
    .rot  (rot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= 4'b0000;
      out_id   <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (xfer) state <= FULL;
        FULL:  if (out_ready && !xfer) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (xfer) begin
        out_data <= rot;
        out_id   <= sel;
        last_id  <= sel;
      end
    end
  end
endmodule
